// File: rtl/systolic_feeder.sv
// Operand loader and skewed edge-stream driver for a 3x3 systolic multiplier.
// Stores A/B from a serial word stream, feeds them diagonally, and watches Done.
module systolic_feeder #(
  parameter int DATAWIDTN = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTN-1:0] in_data,
  output logic [DATAWIDTN-1:0] A0,
  output logic [DATAWIDTN-1:0] A1,
  output logic [DATAWIDTN-1:0] A2,
  output logic [DATAWIDTN-1:0] B0,
  output logic [DATAWIDTN-1:0] B1,
  output logic [DATAWIDTN-1:0] B2,
  output logic [1:0]           start_out,
  input  logic                 done_in,
  output logic                 res_valid,
  output logic                 err,
  output logic                 busy
);

  typedef enum logic [1:0] {S_LOAD, S_FEED, S_WAIT, S_DONE} state_e;

  state_e state_q, state_d;
  logic [4:0] k_q, k_d;
  logic [2:0] t_q, t_d;
  logic [3:0] w_q, w_d;

  logic [2:0][2:0][DATAWIDTN-1:0] am_q, bm_q;
  logic [2:0][DATAWIDTN-1:0]      a_q, a_d, b_q, b_d;

  logic       accept, last_word, timeout, feed_next;
  logic [2:0] tn;

  assign accept    = (state_q == S_LOAD) && in_valid;
  assign last_word = accept && (k_q == 5'd17);
  // Timeout fires in the TIMEOUT-th WAIT cycle that still has no done_in.
  assign timeout   = (state_q == S_WAIT) && !done_in && (w_q == 4'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_LOAD;
      k_q     <= '0;
      t_q     <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      t_q     <= t_d;
      w_q     <= w_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    t_d     = t_q;
    w_d     = w_q;
    case (state_q)
      S_LOAD: begin
        if (accept) begin
          if (last_word) begin
            state_d = S_FEED;
            k_d     = '0;
            t_d     = '0;
          end else begin
            k_d = k_q + 5'd1;
          end
        end
      end
      S_FEED: begin
        if (t_q == 3'd7) begin
          state_d = S_WAIT;
          w_d     = '0;
        end else begin
          t_d = t_q + 3'd1;
        end
      end
      S_WAIT: begin
        if (done_in)      state_d = S_DONE;
        else if (timeout) state_d = S_LOAD;
        else              w_d = w_q + 4'd1;
      end
      S_DONE:  state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_LOAD);
    busy      = (state_q != S_LOAD);
    start_out = (state_q == S_FEED) ? 2'b01 : 2'b00;
    res_valid = (state_q == S_DONE);
    err       = timeout;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      am_q <= '0;
      bm_q <= '0;
    end else if (accept) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          if (k_q == 5'(3*i + j))     am_q[i][j] <= in_data;
          if (k_q == 5'(9 + 3*i + j)) bm_q[i][j] <= in_data;
        end
      end
    end
  end

  // Streams are registered, so they are computed for the step the next cycle shows.
  assign feed_next = last_word || ((state_q == S_FEED) && (t_q != 3'd7));
  assign tn        = last_word ? 3'd0 : (t_q + 3'd1);

  always_comb begin
    a_d = '0;
    b_d = '0;
    if (feed_next) begin
      for (int i = 0; i < 3; i++) begin
        for (int s = 0; s < 3; s++) begin
          if (tn == 3'(i + s)) begin
            a_d[i] = am_q[i][s];
            b_d[i] = bm_q[s][i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign A0 = a_q[0];
  assign A1 = a_q[1];
  assign A2 = a_q[2];
  assign B0 = b_q[0];
  assign B1 = b_q[1];
  assign B2 = b_q[2];

endmodule
